// File: rtl/feature_stream_tx_if.sv
// rtl/feature_stream_tx_if.sv - stream, cfg and frame-buffer read signals of feature_stream_tx
interface feature_stream_tx_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int CFG_W  = 32
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_fast_rdata;
    logic [DATA_W-1:0] mem_pixel_rdata;

    logic [CFG_W-1:0]  cfg_tdata;
    logic              cfg_tvalid;
    logic              cfg_tlast;
    logic              cfg_tready;

    logic [DATA_W-1:0] fast_tdata;
    logic              fast_tvalid;
    logic              fast_tlast;
    logic              fast_tready;

    logic [DATA_W-1:0] pixel_tdata;
    logic              pixel_tvalid;
    logic              pixel_tready;

    modport master (
        output mem_rd_en, mem_rd_addr,
        input  mem_fast_rdata, mem_pixel_rdata,
        output cfg_tdata, cfg_tvalid, cfg_tlast,
        input  cfg_tready,
        output fast_tdata, fast_tvalid, fast_tlast,
        input  fast_tready,
        output pixel_tdata, pixel_tvalid,
        input  pixel_tready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr,
        output mem_fast_rdata, mem_pixel_rdata,
        input  cfg_tdata, cfg_tvalid, cfg_tlast,
        output cfg_tready,
        input  fast_tdata, fast_tvalid, fast_tlast,
        output fast_tready,
        input  pixel_tdata, pixel_tvalid,
        output pixel_tready
    );
endinterface

// File: rtl/feature_stream_tx.sv
// rtl/feature_stream_tx.sv - cfg packet then one frame of fast/pixel beats read from a frame buffer
module feature_stream_tx #(
    parameter int WIDTH_W  = 10,
    parameter int HEIGHT_W = 9,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 8,
    parameter int CFG_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH_W-1:0]  frame_width,
    input  logic [HEIGHT_W-1:0] frame_height,
    output logic                busy,
    output logic                done,
    feature_stream_tx_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CFG_W  = 3'd1;
    localparam logic [2:0] S_CFG_H  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]          state;
    logic [WIDTH_W-1:0]  w_q;
    logic [HEIGHT_W-1:0] h_q;
    logic [ADDR_W-1:0]   total;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   beat_cnt;
    logic                inflight;

    logic [DATA_W-1:0]   fifo_fast [2];
    logic [DATA_W-1:0]   fifo_pixel [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          occ;

    logic                rd_en;
    logic                out_valid;
    logic                xfer;
    logic                cfg_xfer;
    logic                last_beat;
    logic                push;
    logic                pop;
    logic [DATA_W-1:0]   head_fast;
    logic [DATA_W-1:0]   head_pixel;
    logic                start_ok;

    // Reads are budgeted against occupancy plus the read in flight, so a
    // returning word always has a FIFO slot even if the sink stalls.
    always_comb begin
        rd_en     = (state == S_STREAM) && (rd_addr < total) &&
                    ((occ == 2'd0) || ((occ == 2'd1) && !inflight));
        out_valid = (state == S_STREAM) && ((occ != 2'd0) || inflight);
        xfer      = out_valid && bus.fast_tready && bus.pixel_tready;
        cfg_xfer  = bus.cfg_tvalid && bus.cfg_tready;
        last_beat = (beat_cnt == total - ADDR_W'(1));
        // With an empty FIFO the returning word is presented directly and is
        // only stored if the sink does not take it this cycle.
        push      = inflight && !((occ == 2'd0) && xfer);
        pop       = xfer && (occ != 2'd0);
        start_ok  = start && (frame_width != '0) && (frame_height != '0);
        if (occ != 2'd0) begin
            head_fast  = fifo_fast[rd_ptr];
            head_pixel = fifo_pixel[rd_ptr];
        end else begin
            head_fast  = bus.mem_fast_rdata;
            head_pixel = bus.mem_pixel_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            w_q      <= '0;
            h_q      <= '0;
            total    <= '0;
            rd_addr  <= '0;
            beat_cnt <= '0;
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
        end else begin
            inflight <= rd_en;
            if (rd_en)
                rd_addr <= rd_addr + ADDR_W'(1);
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (xfer)
                beat_cnt <= beat_cnt + ADDR_W'(1);

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        w_q      <= frame_width;
                        h_q      <= frame_height;
                        total    <= ADDR_W'(frame_width) * ADDR_W'(frame_height);
                        rd_addr  <= '0;
                        beat_cnt <= '0;
                        state    <= S_CFG_W;
                    end
                end
                S_CFG_W:  if (cfg_xfer) state <= S_CFG_H;
                S_CFG_H:  if (cfg_xfer) state <= S_STREAM;
                S_STREAM: if (xfer && last_beat) state <= S_DONE;
                S_DONE:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_fast[wr_ptr]  <= bus.mem_fast_rdata;
            fifo_pixel[wr_ptr] <= bus.mem_pixel_rdata;
        end
    end

    always_comb begin
        busy             = (state != S_IDLE);
        done             = (state == S_DONE);
        bus.cfg_tvalid   = (state == S_CFG_W) || (state == S_CFG_H);
        bus.cfg_tlast    = (state == S_CFG_H);
        bus.cfg_tdata    = '0;
        if (state == S_CFG_W)
            bus.cfg_tdata = CFG_W'(w_q);
        else if (state == S_CFG_H)
            bus.cfg_tdata = CFG_W'(h_q);
        bus.mem_rd_en    = rd_en;
        bus.mem_rd_addr  = rd_en ? rd_addr : '0;
        bus.fast_tvalid  = out_valid;
        bus.pixel_tvalid = out_valid;
        bus.fast_tlast   = out_valid && last_beat;
        bus.fast_tdata   = out_valid ? head_fast : '0;
        bus.pixel_tdata  = out_valid ? head_pixel : '0;
    end
endmodule

// File: tb/tb_feature_stream_tx.sv
// tb/tb_feature_stream_tx.sv - scoreboard bench for feature_stream_tx
module tb_feature_stream_tx;
    localparam int WIDTH_W = 10, HEIGHT_W = 9, ADDR_W = 19, DATA_W = 8, CFG_W = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [WIDTH_W-1:0]  frame_width = '0;
    logic [HEIGHT_W-1:0] frame_height = '0;
    logic                busy;
    logic                done;

    feature_stream_tx_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CFG_W(CFG_W)) bus ();

    feature_stream_tx #(
        .WIDTH_W(WIDTH_W), .HEIGHT_W(HEIGHT_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CFG_W(CFG_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frame_width(frame_width),
        .frame_height(frame_height), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] f; logic [7:0] p; logic l;} beat_t;
    typedef struct packed {logic [31:0] d; logic l;} cfgb_t;
    beat_t exp_q[$];
    cfgb_t cfg_q[$];

    int checks = 0, failures = 0;
    int cyc = 0;
    int cur_total = 0, cfg_beats = 0, cfg_last_cyc = 0, data_beats = 0;
    int first_xfer_cyc = -1, last_xfer_cyc = 0, done_count = 0, last_rd_addr = -1;
    bit seen_valid = 0, frame_done = 0, check_en = 0;
    int cfg_mode = 0, data_mode = 0, cfg_wait = 0;

    logic prev_cv = 0, prev_cx = 0, prev_cl = 0, prev_fv = 0, prev_fx = 0, prev_fl = 0;
    logic [31:0] prev_cd = '0;
    logic [7:0]  prev_f = '0, prev_p = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame buffer: fast = addr[7:0], pixel = 0x80 + addr[7:0]; junk when not read.
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_fast_rdata  <= bus.mem_rd_addr[7:0];
            bus.mem_pixel_rdata <= 8'h80 + bus.mem_rd_addr[7:0];
        end else begin
            bus.mem_fast_rdata  <= 8'($urandom);
            bus.mem_pixel_rdata <= 8'($urandom);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Ready driver: cfg mode 1 holds cfg_tready low 3 cycles per beat; data mode 1 is 50% random.
    always @(posedge clk) begin
        #2;
        if (cfg_mode == 0) begin
            bus.cfg_tready = 1'b1;
        end else if (bus.cfg_tvalid && cfg_wait < 3) begin
            bus.cfg_tready = 1'b0;
            cfg_wait++;
        end else if (bus.cfg_tvalid) begin
            bus.cfg_tready = 1'b1;
            cfg_wait = 0;
        end else begin
            bus.cfg_tready = 1'b0;
        end
        if (data_mode == 0) begin
            bus.fast_tready  = 1'b1;
            bus.pixel_tready = 1'b1;
        end else begin
            bus.fast_tready  = 1'($urandom_range(0, 1));
            bus.pixel_tready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (rst || !check_en) begin
            prev_cv = 0; prev_cx = 0; prev_fv = 0; prev_fx = 0;
        end else begin
            logic cx, fx;
            cfgb_t ce;
            beat_t be;
            cx = bus.cfg_tvalid && bus.cfg_tready;
            fx = bus.fast_tvalid && bus.fast_tready && bus.pixel_tready;
            chk("tvalid_equal", bus.fast_tvalid, bus.pixel_tvalid);
            if (prev_cv && !prev_cx) begin
                chk("cfg_hold", {bus.cfg_tvalid, bus.cfg_tlast, bus.cfg_tdata}, {1'b1, prev_cl, prev_cd});
            end
            if (prev_fv && !prev_fx) begin
                chk("data_hold", {bus.fast_tvalid, bus.fast_tlast, bus.fast_tdata, bus.pixel_tdata},
                    {1'b1, prev_fl, prev_f, prev_p});
            end
            if (cx) begin
                chk("cfg_expected", cfg_q.size() != 0, 1'b1);
                if (cfg_q.size() != 0) begin
                    ce = cfg_q.pop_front();
                    chk("cfg_tdata", bus.cfg_tdata, ce.d);
                    chk("cfg_tlast", bus.cfg_tlast, ce.l);
                end
                cfg_beats++;
                if (bus.cfg_tlast) cfg_last_cyc = cyc;
            end
            if (bus.mem_rd_en) begin
                chk("rd_after_cfg", 32'(cfg_beats), 32'd2);
                chk("rd_addr_range", bus.mem_rd_addr < ADDR_W'(cur_total), 1'b1);
                last_rd_addr = int'(bus.mem_rd_addr);
            end
            if (bus.fast_tvalid && !seen_valid) begin
                seen_valid = 1;
                chk("valid_latency", 32'(cyc - cfg_last_cyc), 32'd2);
            end
            if (fx) begin
                chk("data_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    be = exp_q.pop_front();
                    chk("beat", {bus.fast_tdata, bus.pixel_tdata, bus.fast_tlast}, {be.f, be.p, be.l});
                end
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                data_beats++;
            end
            if (done) begin
                done_count++;
                frame_done = 1;
                chk("done_after_last", 32'(cyc - last_xfer_cyc), 32'd1);
                chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
            end
            prev_cv = bus.cfg_tvalid; prev_cx = cx; prev_cl = bus.cfg_tlast; prev_cd = bus.cfg_tdata;
            prev_fv = bus.fast_tvalid; prev_fx = fx; prev_fl = bus.fast_tlast;
            prev_f = bus.fast_tdata; prev_p = bus.pixel_tdata;
        end
    end

    task automatic clear_frame();
        exp_q.delete();
        cfg_q.delete();
        cfg_beats = 0; data_beats = 0; seen_valid = 0; frame_done = 0;
        first_xfer_cyc = -1; done_count = 0; last_rd_addr = -1;
    endtask

    task automatic start_frame(input logic [WIDTH_W-1:0] w, input logic [HEIGHT_W-1:0] h);
        beat_t b;
        clear_frame();
        cur_total = int'(w) * int'(h);
        cfg_q.push_back({32'(w), 1'b0});
        cfg_q.push_back({32'(h), 1'b1});
        for (int i = 0; i < cur_total; i++) begin
            b.f = 8'(i);
            b.p = 8'h80 + 8'(i);
            b.l = (i == cur_total - 1);
            exp_q.push_back(b);
        end
        @(posedge clk); #1;
        frame_width = w; frame_height = h; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !frame_done; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_seen"}, frame_done, 1'b1);
        chk({tag, "_done_once"}, 32'(done_count), 32'd1);
        chk({tag, "_beats"}, 32'(data_beats), 32'(cur_total));
        chk({tag, "_idle"}, {busy, done}, 2'b00);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, {busy, done, bus.cfg_tvalid, bus.cfg_tlast, bus.fast_tvalid,
                             bus.fast_tlast, bus.pixel_tvalid, bus.mem_rd_en}, 8'd0);
        chk({tag, "_data"}, {bus.cfg_tdata, bus.fast_tdata, bus.pixel_tdata, bus.mem_rd_addr}, 67'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_hold");
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset_state");
        check_en = 1;

        // 4x2, full ready: 8 back-to-back beats
        start_frame(10'd4, 9'd2);
        wait_done("f4x2", 200);
        chk("f4x2_no_bubbles", 32'(last_xfer_cyc - first_xfer_cyc), 32'd7);

        // 4x2 with cfg_tready stalled 3 cycles per cfg beat
        cfg_mode = 1;
        start_frame(10'd4, 9'd2);
        wait_done("cfg_stall", 200);
        cfg_mode = 0;

        // 3x3 with independent random readies
        data_mode = 1;
        start_frame(10'd3, 9'd3);
        wait_done("rand3x3", 500);
        chk("rand3x3_last_addr", 32'(last_rd_addr), 32'd8);

        // start during STREAM is ignored
        start_frame(10'd3, 9'd2);
        for (int i = 0; i < 100 && !seen_valid; i++) @(posedge clk);
        #1;
        frame_width = 10'd5; frame_height = 9'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_start", 500);
        data_mode = 0;

        // zero width start while idle is ignored
        clear_frame();
        @(posedge clk); #1;
        frame_width = 10'd0; frame_height = 9'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("zero_dim_busy", {busy, done, bus.cfg_tvalid}, 3'b000);
            @(posedge clk); #1;
        end
        chk("zero_dim_no_done", 32'(done_count), 32'd0);

        // reset after beat 5 of a 4x2 frame, then 2x1
        start_frame(10'd4, 9'd2);
        for (int i = 0; i < 100 && data_beats < 5; i++) @(negedge clk);
        check_en = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("mid_reset");
        rst = 1'b0;
        clear_frame();
        check_en = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_reset_idle", {busy, done}, 2'b00);
        start_frame(10'd2, 9'd1);
        wait_done("after_reset", 200);
        chk("after_reset_last_addr", 32'(last_rd_addr), 32'd1);

        // smallest frame
        start_frame(10'd1, 9'd1);
        wait_done("f1x1", 100);

        // larger frame at full rate
        start_frame(10'd64, 9'd32);
        wait_done("f64x32", 4000);
        chk("f64x32_no_bubbles", 32'(last_xfer_cyc - first_xfer_cyc), 32'd2047);
        chk("f64x32_last_addr", 32'(last_rd_addr), 32'd2047);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
